// File: rtl/tick_pkg.sv
// Shared types and defaults for the tick period meter.
// State encodings are fixed; the unused code 2'd3 recovers to IDLE in the FSM.
package tick_pkg;

   localparam int W_DEF        = 8;
   localparam int LOCK_CNT_DEF = 3;

   localparam logic [1:0] IDLE_ENC = 2'd0;
   localparam logic [1:0] MEAS_ENC = 2'd1;
   localparam logic [1:0] LOCK_ENC = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = IDLE_ENC,
      ST_MEAS = MEAS_ENC,
      ST_LOCK = LOCK_ENC
   } tick_state_e;

   // Increment that sticks at lim so the match count never wraps.
   function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
      return (v >= lim) ? lim : v + 4'd1;
   endfunction

endpackage

// File: rtl/tick_period_meter_period_cmp_ctr.sv
// Match counter and lock comparator: counts consecutive equal periods and
// raises locked once LOCK_CNT of them have been seen in a row.
module period_cmp_ctr
   import tick_pkg::*;
#(
   parameter int W        = W_DEF,
   parameter int LOCK_CNT = LOCK_CNT_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         evt,
   input  logic [W-1:0] cnt,
   input  logic [W-1:0] period,
   output logic         locked,
   output logic         locked_d
);

   localparam logic [3:0] LOCK_LIM = 4'(LOCK_CNT);

   logic [3:0] match_q, match_d;
   logic       locked_q;

   always_comb begin
      match_d  = match_q;
      locked_d = locked_q;
      if (clear) begin
         match_d  = 4'd0;
         locked_d = 1'b0;
      end else if (evt) begin
         // match==0 means no valid previous period to compare against
         if (match_q == 4'd0 || cnt != period)
            match_d = 4'd1;
         else
            match_d = sat_inc(match_q, LOCK_LIM);
         locked_d = (match_d >= LOCK_LIM);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         match_q  <= 4'd0;
         locked_q <= 1'b0;
      end else begin
         match_q  <= match_d;
         locked_q <= locked_d;
      end
   end

   assign locked = locked_q;

endmodule

// File: rtl/tick_period_meter.sv
// Measures clk cycles between tick pulses, reports the period, lock and overflow.
// Define TICK_PERIOD_STATS_EN to add running pmin/pmax outputs.
module tick_period_meter
   import tick_pkg::*;
#(
   parameter int W        = W_DEF,
   parameter int LOCK_CNT = LOCK_CNT_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         tick,
   output logic [W-1:0] period,
   output logic         period_vld,
   output logic         locked,
`ifdef TICK_PERIOD_STATS_EN
   output logic         ovf,
   output logic [W-1:0] pmin,
   output logic [W-1:0] pmax
`else
   output logic         ovf
`endif
);

   localparam logic [W-1:0] CNT_MAX = '1;

   tick_state_e  state_q, state_d;
   logic [W-1:0] cnt_q, cnt_d;
   logic [W-1:0] period_q, period_d;
   logic         period_vld_q, period_vld_d;
   logic         ovf_q, ovf_d;

   logic measuring;
   logic acc_evt;
   logic sat_evt;
   logic lock_nxt;

   assign measuring = (state_q == ST_MEAS) || (state_q == ST_LOCK);
   assign acc_evt   = !clr && measuring && tick;
   assign sat_evt   = !clr && measuring && !tick && (cnt_q == CNT_MAX);

   period_cmp_ctr #(
      .W        (W),
      .LOCK_CNT (LOCK_CNT)
   ) u_cmp (
      .clk      (clk),
      .rst      (rst),
      .clear    (clr | sat_evt),
      .evt      (acc_evt),
      .cnt      (cnt_q),
      .period   (period_q),
      .locked   (locked),
      .locked_d (lock_nxt)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      period_d     = period_q;
      period_vld_d = 1'b0;
      ovf_d        = ovf_q;
      if (clr) begin
         state_d  = ST_IDLE;
         cnt_d    = '0;
         period_d = '0;
         ovf_d    = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (tick) begin
                  state_d = ST_MEAS;
                  cnt_d   = W'(1);
               end
            end
            ST_MEAS, ST_LOCK: begin
               if (acc_evt) begin
                  period_d     = cnt_q;
                  period_vld_d = 1'b1;
                  cnt_d        = W'(1);
                  state_d      = lock_nxt ? ST_LOCK : ST_MEAS;
               end else if (sat_evt) begin
                  // Ticks stopped: abandon the measurement, keep the last period
                  ovf_d   = 1'b1;
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + W'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         period_q     <= '0;
         period_vld_q <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         period_q     <= period_d;
         period_vld_q <= period_vld_d;
         ovf_q        <= ovf_d;
      end
   end

   assign period     = period_q;
   assign period_vld = period_vld_q;
   assign ovf        = ovf_q;

`ifdef TICK_PERIOD_STATS_EN
   logic [W-1:0] pmin_q, pmin_d;
   logic [W-1:0] pmax_q, pmax_d;

   // Reset values make the first measurement load both extremes naturally.
   always_comb begin
      pmin_d = pmin_q;
      pmax_d = pmax_q;
      if (clr) begin
         pmin_d = '1;
         pmax_d = '0;
      end else if (acc_evt) begin
         if (cnt_q < pmin_q) pmin_d = cnt_q;
         if (cnt_q > pmax_q) pmax_d = cnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pmin_q <= '1;
         pmax_q <= '0;
      end else begin
         pmin_q <= pmin_d;
         pmax_q <= pmax_d;
      end
   end

   assign pmin = pmin_q;
   assign pmax = pmax_q;
`else
`endif

endmodule
